chip8_timer_ctrl: RTL and testbench
===================================

// Module: chip8_timer_ctrl
// PURPOSE
//  Chip-8 delay/sound timer controller in the clk_12k domain. Derives the 60 Hz timer tick,
//  holds DT and ST, services CPU load/read requests over a 4-phase req/ack handshake and
//  gates a square-wave tone onto the audio path while ST is active. Sits beside the chip8
//  machine; its audio_o drives the board-level audio enable.
// PARAMETERS
//  CLK_HZ    12000  input clock frequency (Hz)
//  TICK_HZ   60     timer decrement rate; DIV = CLK_HZ/TICK_HZ = 200
//  TONE_DIV  24     audio_o half-period in clk cycles (250 Hz at defaults)
//  ST_MIN    1      sound is active while st_o >= ST_MIN
// PORTS
//  clk_12k        in   1  timer clock
//  reset          in   1  synchronous, active-high
//  req_i          in   1  4-phase request from CPU domain; synchronized internally
//  req_op_i       in   2  00 read DT, 01 write DT, 10 write ST, 11 reserved
//  req_data_i     in   8  write data; stable while req_i high
//  ack_o          out  1  handshake acknowledge
//  rd_data_o      out  8  DT value captured on a read; valid while ack_o high
//  dt_o           out  8  current delay timer
//  st_o           out  8  current sound timer
//  tick_o         out  1  one-cycle 60 Hz strobe
//  sound_active_o out  1  st_o >= ST_MIN
//  audio_o        out  1  square-wave tone, 0 when silent
// BEHAVIOUR
//  - Reset: all outputs 0, prescaler 0, tone counter 0, FSM IDLE, sync flops 0.
//  - Prescaler counts 0..DIV-1, wraps; tick_o=1 in the cycle where count==DIV-1 (period 200).
//  - On tick: DT>0 -> DT-1; ST>0 -> ST-1; a zero timer stays 0 (no wrap).
//  - req_i passes a 2-FF synchronizer -> req_s. FSM:
//      IDLE: req_s=1 -> EXEC
//      EXEC: perform op for one cycle -> ACK (ack_o registered high)
//      ACK : hold ack_o=1 until req_s=0 -> IDLE, ack_o=0
//  - Latency: ack_o high after the 4th clk edge sampling req_i high; ack_o low after the 3rd
//    edge sampling req_i low.
//  - Read: rd_data_o <= DT register value at EXEC (pre-decrement if tick coincides).
//  - Write with coincident tick: written timer takes req_data_i (write wins); other timer
//    decrements normally.
//  - Reserved op: acknowledged, no state change, rd_data_o unchanged.
//  - Reset mid-handshake: ack_o 0 next cycle, FSM IDLE; a req_i still high after reset
//    is treated as a new request.
//  - Audio: sound_active_o combinational from st_o. While active, tone counter counts
//    0..TONE_DIV-1 and audio_o toggles at wrap; when inactive, counter and audio_o forced 0.
//  - All arithmetic 8-bit unsigned; prescaler width $clog2(DIV).
// CONFIGURATION
//  CHIP8_TIMER_PAUSE_EN defined: adds input pause_i (1 bit, after reset in port list).
//   pause_i=1 holds prescaler, suppresses tick_o and decrements, forces audio_o=0 and
//   holds the tone counter; handshake still services reads and writes.
//  Undefined: port absent, timers always run.
// STRUCTURE
//  - chip8_pkg: typedef enum logic [1:0] timer_op_t {OP_RD_DT, OP_WR_DT, OP_WR_ST, OP_RSVD};
//    localparam TIMER_W = 8; FSM state enum tctl_state_t {IDLE, EXEC, ACK}.
//  - Sub-module chip8_req_sync: 2-FF level synchronizer, reset to 0.
//  - Prescaler, timer registers, FSM and tone generator stay inline.
// TESTING
//  1. Reset released, idle 1000 cycles -> dt_o=st_o=0, audio_o=0, tick_o pulses every 200 cycles.
//  2. Write DT=3 -> ack_o high 4 cycles after req_i; dt_o=3, then 2,1,0 on 3 ticks, holds 0.
//  3. Write ST=2 -> sound_active_o=1, audio_o toggles every 24 cycles; 0 after 2 ticks.
//  4. Write DT=5 landing EXEC on a tick cycle with ST=4 -> dt_o=5, st_o=3 same cycle.
//  5. DT=0x10, read DT -> rd_data_o=0x10 with ack_o; op 11 with data 0xFF -> ack, dt/st unchanged.
//  6. Assert reset while ack_o=1, ST=9 -> next cycle ack_o=0, st_o=0, audio_o=0;
//     with CHIP8_TIMER_PAUSE_EN, pause_i=1 for 600 cycles -> no tick_o, DT unchanged.

Source files
------------

// File: rtl/chip8_pkg.sv
// rtl/chip8_pkg.sv - shared types and helpers for the chip8 timer controller
// Contents: TIMER_W (timer register width), timer_op_t (CPU request opcodes),
//           tctl_state_t (handshake FSM states), timer_dec (saturating decrement).
package chip8_pkg;

  localparam int TIMER_W = 8;

  typedef enum logic [1:0] {
    OP_RD_DT = 2'b00,
    OP_WR_DT = 2'b01,
    OP_WR_ST = 2'b10,
    OP_RSVD  = 2'b11
  } timer_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    ACK  = 2'b10
  } tctl_state_t;

  // Timers stop at zero instead of wrapping to 0xFF.
  function automatic logic [TIMER_W-1:0] timer_dec(input logic [TIMER_W-1:0] v);
    return (v == '0) ? v : v - TIMER_W'(1);
  endfunction

endpackage

// File: rtl/chip8_req_sync.sv
// rtl/chip8_req_sync.sv - 2-FF level synchronizer for the CPU request line
// Ports: clk_12k (clock), reset (sync, active-high), d_i (async level in),
//        q_o (level synchronized to clk_12k, two cycles of latency).
module chip8_req_sync (
  input  logic clk_12k,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic s1_d, s1_q;
  logic s2_d, s2_q;

  always_comb begin
    s1_d = d_i;
    s2_d = s1_q;
  end

  always_ff @(posedge clk_12k) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/chip8_timer_ctrl.sv
// rtl/chip8_timer_ctrl.sv - Chip-8 delay/sound timers with 60 Hz tick, req/ack access and tone gate
// Ports: clk_12k, reset (sync, active-high), [pause_i when CHIP8_TIMER_PAUSE_EN],
//        req_i/req_op_i/req_data_i (4-phase CPU request), ack_o, rd_data_o (DT read value),
//        dt_o, st_o (timers), tick_o (60 Hz strobe), sound_active_o, audio_o (square tone).
// Optional feature macro: CHIP8_TIMER_PAUSE_EN (adds pause_i, freezes timers and tone).
module chip8_timer_ctrl
  import chip8_pkg::*;
#(
  parameter int CLK_HZ   = 12000,
  parameter int TICK_HZ  = 60,
  parameter int TONE_DIV = 24,
  parameter int ST_MIN   = 1
) (
  input  logic               clk_12k,
  input  logic               reset,
`ifdef CHIP8_TIMER_PAUSE_EN
  input  logic               pause_i,
`endif
  input  logic               req_i,
  input  logic [1:0]         req_op_i,
  input  logic [TIMER_W-1:0] req_data_i,
  output logic               ack_o,
  output logic [TIMER_W-1:0] rd_data_o,
  output logic [TIMER_W-1:0] dt_o,
  output logic [TIMER_W-1:0] st_o,
  output logic               tick_o,
  output logic               sound_active_o,
  output logic               audio_o
);

  localparam int DIV    = CLK_HZ / TICK_HZ;
  localparam int PRE_W  = $clog2(DIV);
  localparam int TONE_W = $clog2(TONE_DIV);
  localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(DIV - 1);
  localparam logic [TONE_W-1:0]  TONE_LAST = TONE_W'(TONE_DIV - 1);
  localparam logic [TIMER_W-1:0] ST_MIN_V  = TIMER_W'(ST_MIN);

  logic pause;
`ifdef CHIP8_TIMER_PAUSE_EN
  assign pause = pause_i;
`else
  assign pause = 1'b0;
`endif

  // Request synchronizer
  logic req_s;

  chip8_req_sync u_req_sync (
    .clk_12k (clk_12k),
    .reset   (reset),
    .d_i     (req_i),
    .q_o     (req_s)
  );

  // Prescaler: tick is high for the whole cycle in which the count sits at DIV-1
  logic [PRE_W-1:0] presc_d, presc_q;
  logic             tick;

  always_comb begin
    presc_d = presc_q;
    if (!pause) begin
      presc_d = (presc_q == PRE_LAST) ? '0 : presc_q + PRE_W'(1);
    end
  end

  assign tick = !pause && (presc_q == PRE_LAST);

  // Handshake FSM; op is executed during the single EXEC cycle
  tctl_state_t        state_q;
  logic               ack_q;
  logic [TIMER_W-1:0] rd_data_q;
  logic [TIMER_W-1:0] dt_d, dt_q;
  logic [TIMER_W-1:0] st_d, st_q;
  timer_op_t          op;

  assign op = timer_op_t'(req_op_i);

  always_ff @(posedge clk_12k) begin
    if (reset) begin
      state_q   <= IDLE;
      ack_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_s) state_q <= EXEC;
        end
        EXEC: begin
          state_q <= ACK;
          ack_q   <= 1'b1;
          // Captures the register value, so a coincident tick is not yet applied
          if (op == OP_RD_DT) rd_data_q <= dt_q;
        end
        ACK: begin
          if (!req_s) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  // Timers: a CPU write overrides the tick on the written timer only
  always_comb begin
    dt_d = tick ? timer_dec(dt_q) : dt_q;
    st_d = tick ? timer_dec(st_q) : st_q;
    if (state_q == EXEC) begin
      case (op)
        OP_WR_DT: dt_d = req_data_i;
        OP_WR_ST: st_d = req_data_i;
        default:  ;
      endcase
    end
  end

  // Tone generator: runs only while sound is active, frozen while paused
  logic              sound_active;
  logic [TONE_W-1:0] tone_d, tone_q;
  logic              audio_d, audio_q;

  assign sound_active = (st_q >= ST_MIN_V);

  always_comb begin
    tone_d  = tone_q;
    audio_d = audio_q;
    if (!sound_active) begin
      tone_d  = '0;
      audio_d = 1'b0;
    end else if (!pause) begin
      if (tone_q == TONE_LAST) begin
        tone_d  = '0;
        audio_d = ~audio_q;
      end else begin
        tone_d = tone_q + TONE_W'(1);
      end
    end
  end

  always_ff @(posedge clk_12k) begin
    if (reset) begin
      presc_q <= '0;
      dt_q    <= '0;
      st_q    <= '0;
      tone_q  <= '0;
      audio_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      dt_q    <= dt_d;
      st_q    <= st_d;
      tone_q  <= tone_d;
      audio_q <= audio_d;
    end
  end

  assign ack_o          = ack_q;
  assign rd_data_o      = rd_data_q;
  assign dt_o           = dt_q;
  assign st_o           = st_q;
  assign tick_o         = tick;
  assign sound_active_o = sound_active;
  // Gated so the pin drops in the same cycle the sound timer reaches zero
  assign audio_o        = audio_q & sound_active & ~pause;

endmodule

// File: tb/tb_chip8_timer_ctrl.sv
// tb/tb_chip8_timer_ctrl.sv - directed self-checking bench for chip8_timer_ctrl
module tb_chip8_timer_ctrl;

  logic       clk_12k = 1'b0;
  logic       reset;
`ifdef CHIP8_TIMER_PAUSE_EN
  logic       pause_i;
`endif
  logic       req_i;
  logic [1:0] req_op_i;
  logic [7:0] req_data_i;
  logic       ack_o;
  logic [7:0] rd_data_o;
  logic [7:0] dt_o;
  logic [7:0] st_o;
  logic       tick_o;
  logic       sound_active_o;
  logic       audio_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;   // edges since the last reset edge; prescaler count == cyc % 200

  chip8_timer_ctrl dut (
    .clk_12k        (clk_12k),
    .reset          (reset),
`ifdef CHIP8_TIMER_PAUSE_EN
    .pause_i        (pause_i),
`endif
    .req_i          (req_i),
    .req_op_i       (req_op_i),
    .req_data_i     (req_data_i),
    .ack_o          (ack_o),
    .rd_data_o      (rd_data_o),
    .dt_o           (dt_o),
    .st_o           (st_o),
    .tick_o         (tick_o),
    .sound_active_o (sound_active_o),
    .audio_o        (audio_o)
  );

  always #5 clk_12k = ~clk_12k;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk_12k);
    #1;
    cyc += n;
  endtask

  // Full 4-phase transaction with latency checks; returns rd_data_o seen with ack
  task automatic do_req(input logic [1:0] op, input logic [7:0] data, input string tag,
                        output logic [7:0] rd);
    req_op_i   = op;
    req_data_i = data;
    req_i      = 1'b1;
    step(3);
    check({tag, " ack not early"}, ack_o, 1'b0);
    step(1);
    check({tag, " ack after 4 edges"}, ack_o, 1'b1);
    rd    = rd_data_o;
    req_i = 1'b0;
    step(2);
    check({tag, " ack held"}, ack_o, 1'b1);
    step(1);
    check({tag, " ack released"}, ack_o, 1'b0);
  endtask

  // Step until tick_o (bounded), confirm its phase, then step past the decrement edge
  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    while (tick_o !== 1'b1 && n < 400) begin
      step(1);
      n++;
    end
    check({tag, " tick seen"}, (n < 400), 1'b1);
    check({tag, " tick phase"}, cyc % 200, 199);
    step(1);
  endtask

  logic [7:0] rd;
  int         mism;
  int         nticks;

  initial begin
    reset      = 1'b1;
    req_i      = 1'b0;
    req_op_i   = 2'b00;
    req_data_i = 8'h00;
`ifdef CHIP8_TIMER_PAUSE_EN
    pause_i    = 1'b0;
`endif
    step(3);
    reset = 1'b0;
    cyc   = 0;

    // 1. reset state and idle tick cadence
    check("reset dt", dt_o, 8'h00);
    check("reset st", st_o, 8'h00);
    check("reset ack", ack_o, 1'b0);
    check("reset rd_data", rd_data_o, 8'h00);
    check("reset tick", tick_o, 1'b0);
    check("reset audio", audio_o, 1'b0);
    check("reset sound_active", sound_active_o, 1'b0);
    mism   = 0;
    nticks = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      if (tick_o === 1'b1) nticks++;
      if (tick_o !== ((cyc % 200) == 199)) mism++;
    end
    check("idle tick placement", mism, 0);
    check("idle tick count", nticks, 5);
    check("idle dt", dt_o, 8'h00);
    check("idle audio", audio_o, 1'b0);

    // 2. write DT=3 and count down to 0, holding at 0
    do_req(2'b01, 8'h03, "wr_dt3", rd);
    check("dt after write", dt_o, 8'h03);
    wait_tick("dt3->2");
    check("dt 2", dt_o, 8'h02);
    wait_tick("dt2->1");
    check("dt 1", dt_o, 8'h01);
    wait_tick("dt1->0");
    check("dt 0", dt_o, 8'h00);
    wait_tick("dt0 hold");
    check("dt holds 0", dt_o, 8'h00);
    check("st untouched", st_o, 8'h00);

    // 3. write ST=2, tone half-period 24, silence after two ticks
    req_op_i   = 2'b10;
    req_data_i = 8'h02;
    req_i      = 1'b1;
    step(4);
    check("wr_st ack", ack_o, 1'b1);
    check("st 2", st_o, 8'h02);
    check("sound active", sound_active_o, 1'b1);
    check("audio starts low", audio_o, 1'b0);
    req_i = 1'b0;
    step(23);
    check("audio low at 23", audio_o, 1'b0);
    check("wr_st ack released", ack_o, 1'b0);
    step(1);
    check("audio high at 24", audio_o, 1'b1);
    step(23);
    check("audio high at 47", audio_o, 1'b1);
    step(1);
    check("audio low at 48", audio_o, 1'b0);
    wait_tick("st2->1");
    check("st 1", st_o, 8'h01);
    check("still active", sound_active_o, 1'b1);
    wait_tick("st1->0");
    check("st 0", st_o, 8'h00);
    check("sound off", sound_active_o, 1'b0);
    check("audio off", audio_o, 1'b0);

    // 4. write DT=5 with EXEC on the tick cycle, ST=4 decrements in the same edge
    do_req(2'b10, 8'h04, "wr_st4", rd);
    check("st 4", st_o, 8'h04);
    while ((cyc % 200) != 196) step(1);
    req_op_i   = 2'b01;
    req_data_i = 8'h05;
    req_i      = 1'b1;
    step(3);
    check("exec on tick", tick_o, 1'b1);
    check("dt before exec", dt_o, 8'h00);
    check("st before exec", st_o, 8'h04);
    step(1);
    check("coincide dt write wins", dt_o, 8'h05);
    check("coincide st decrements", st_o, 8'h03);
    check("coincide ack", ack_o, 1'b1);
    req_i = 1'b0;
    step(3);
    check("coincide ack released", ack_o, 1'b0);

    // 5. read DT and a reserved op
    do_req(2'b01, 8'h10, "wr_dt10", rd);
    check("dt 0x10", dt_o, 8'h10);
    do_req(2'b00, 8'h00, "rd_dt", rd);
    check("rd_data with ack", rd, 8'h10);
    do_req(2'b11, 8'hFF, "rsvd", rd);
    check("rsvd dt", dt_o, 8'h10);
    check("rsvd st", st_o, 8'h03);
    check("rsvd rd_data", rd_data_o, 8'h10);

    // 6. reset mid-handshake, then a still-high req is serviced as new
    do_req(2'b10, 8'h09, "wr_st9", rd);
    check("st 9", st_o, 8'h09);
    req_op_i   = 2'b01;
    req_data_i = 8'h10;
    req_i      = 1'b1;
    step(4);
    check("pre-reset ack", ack_o, 1'b1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    cyc   = 0;
    check("mid-reset ack", ack_o, 1'b0);
    check("mid-reset st", st_o, 8'h00);
    check("mid-reset dt", dt_o, 8'h00);
    check("mid-reset audio", audio_o, 1'b0);
    step(3);
    check("post-reset ack not early", ack_o, 1'b0);
    step(1);
    check("post-reset new request ack", ack_o, 1'b1);
    check("post-reset write dt", dt_o, 8'h10);
    req_i = 1'b0;
    step(3);
    check("post-reset ack released", ack_o, 1'b0);

`ifdef CHIP8_TIMER_PAUSE_EN
    pause_i = 1'b1;
    nticks  = 0;
    for (int i = 0; i < 600; i++) begin
      step(1);
      if (tick_o === 1'b1) nticks++;
    end
    check("pause no ticks", nticks, 0);
    check("pause dt held", dt_o, 8'h10);
    pause_i = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
